// File: rtl/tff_downcounter.sv
// Loadable down counter whose next-count logic is a T flip-flop borrow chain.
// Define TFF_DOWNCOUNTER_AUTO_RELOAD_EN for periodic reload at terminal count; default is one-shot.
module tff_downcounter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] toggle;
    logic             done_nx;

    // Bit i toggles on a decrement only when every lower bit is already 0.
    always_comb begin : tff_chain
        logic borrow;
        borrow = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = borrow;
            borrow    = borrow & ~q[i];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nx  = state;
        q_nx      = q;
        reload_nx = reload;
        done_nx   = 1'b0;

        if (load) begin
            q_nx      = load_val;
            reload_nx = load_val;
            state_nx  = (load_val != '0) ? COUNT : IDLE;
        end else if (state == COUNT && en) begin
            if (q == WIDTH'(1)) begin
                done_nx = 1'b1;
`ifdef TFF_DOWNCOUNTER_AUTO_RELOAD_EN
                q_nx    = reload;
`else
                q_nx     = '0;
                state_nx = IDLE;
`endif
            end else if (q == '0) begin
                // Unreachable in normal use; park instead of wrapping to all-ones.
                state_nx = IDLE;
            end else begin
                q_nx = q ^ toggle;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state  <= IDLE;
            q      <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            q      <= q_nx;
            reload <= reload_nx;
            done   <= done_nx;
        end
    end

    assign busy = (state == COUNT);
    assign zero = (q == '0);

endmodule

// File: tb/tb_tff_downcounter.sv
// Self-checking bench for tff_downcounter: arithmetic reference model compared every cycle,
// plus directed literal expectations; follows TFF_DOWNCOUNTER_AUTO_RELOAD_EN like the design.
module tb_tff_downcounter;

    localparam int WIDTH = 3;
`ifdef TFF_DOWNCOUNTER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             zero;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    int m_q      = 0;
    int m_reload = 0;
    bit m_busy   = 1'b0;
    bit m_done   = 1'b0;

    tff_downcounter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer countdown from the documented rules.
    always @(posedge clk) begin
        if (reset) begin
            m_q      <= 0;
            m_reload <= 0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
        end else if (load) begin
            m_q      <= int'(load_val);
            m_reload <= int'(load_val);
            m_busy   <= (load_val != 0);
            m_done   <= 1'b0;
        end else if (m_busy && en) begin
            if (m_q == 1) begin
                m_done <= 1'b1;
                if (AUTO) begin
                    m_q <= m_reload;
                end else begin
                    m_q    <= 0;
                    m_busy <= 1'b0;
                end
            end else begin
                m_q    <= m_q - 1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_q", int'(q), m_q);
            check("model_busy", int'(busy), int'(m_busy));
            check("model_done", int'(done), int'(m_done));
            check("model_zero", int'(zero), int'(m_q == 0));
        end
    end

    task automatic step(input bit r, input bit l, input int v, input bit e);
        reset    = r;
        load     = l;
        load_val = v[WIDTH-1:0];
        en       = e;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int eq, input int ebusy, input int edone);
        check({tag, "_q"}, int'(q), eq);
        check({tag, "_busy"}, int'(busy), ebusy);
        check({tag, "_done"}, int'(done), edone);
        check({tag, "_zero"}, int'(zero), int'(eq == 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int found;
        int exp_q [6];
        int exp_d [6];

        // Reset dominates a simultaneous load and enable.
        step(1, 1, 5, 1);
        check_en = 1'b1;
        expect_out("reset1", 0, 0, 0);
        step(1, 1, 5, 1);
        expect_out("reset2", 0, 0, 0);

        // One-shot countdown from 5.
        step(0, 1, 5, 0);
        expect_out("load5", 5, 1, 0);
        for (int i = 4; i >= 1; i--) begin
            step(0, 0, 0, 1);
            expect_out("count5", i, 1, 0);
        end
        step(0, 0, 0, 1);
        if (AUTO) expect_out("term5", 5, 1, 1);
        else      expect_out("term5", 0, 0, 1);
        step(0, 1, 0, 0);
        expect_out("after5", 0, 0, 0);
        step(0, 0, 0, 1);
        expect_out("idle_en", 0, 0, 0);

        // Maximum load with en alternating; en on the load edge is ignored.
        step(0, 1, 7, 1);
        expect_out("load7", 7, 1, 0);
        found = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, (i % 2) == 0);
            if (done && found == 0) found = i;
            if (found != 0) break;
        end
        check("done_latency7", found, 14);
        step(0, 1, 0, 0);

        // Restart mid-count: load 6, count to 3, then load 2.
        step(0, 1, 6, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("mid6", 3, 1, 0);
        step(0, 1, 2, 1);
        expect_out("reload2", 2, 1, 0);
        step(0, 0, 0, 1);
        expect_out("reload2_1", 1, 1, 0);
        step(0, 0, 0, 1);
        if (AUTO) expect_out("reload2_t", 2, 1, 1);
        else      expect_out("reload2_t", 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // Load zero from COUNT returns to IDLE with no pulse.
        step(0, 1, 0, 0);
        expect_out("load0", 0, 0, 0);

        // Load on the terminal edge wins; no done pulse.
        step(0, 1, 3, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("pre_term", 1, 1, 0);
        step(0, 1, 4, 1);
        expect_out("load_on_term", 4, 1, 0);

        // Reset mid-count suppresses the pending done.
        step(0, 1, 4, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("mid4", 2, 1, 0);
        step(1, 0, 0, 1);
        expect_out("reset_mid", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            expect_out("post_reset", 0, 0, 0);
        end

`ifdef TFF_DOWNCOUNTER_AUTO_RELOAD_EN
        // Periodic: load 3 gives 3,2,1,3,2,1,3 with done on each return to 3.
        exp_q = '{2, 1, 3, 2, 1, 3};
        exp_d = '{0, 0, 1, 0, 0, 1};
        step(0, 1, 3, 1);
        expect_out("per_load3", 3, 1, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1);
            expect_out("per3", exp_q[i], 1, exp_d[i]);
        end
        step(0, 1, 0, 1);
        expect_out("per_load0", 0, 0, 0);

        // Reload value 1 pulses done on every enabled edge.
        step(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            expect_out("per1", 1, 1, 1);
        end
        step(0, 0, 0, 0);
        expect_out("per1_hold", 1, 1, 0);
`else
        exp_q = '{0, 0, 0, 0, 0, 0};
        exp_d = '{0, 0, 0, 0, 0, 0};
        // One-shot with load 1: terminal on the first enabled edge.
        step(0, 1, 1, 0);
        expect_out("load1", 1, 1, 0);
        step(0, 0, 0, 0);
        expect_out("load1_hold", 1, 1, 0);
        step(0, 0, 0, 1);
        expect_out("load1_term", exp_q[0], 0, 1);
        step(0, 0, 0, 1);
        expect_out("load1_after", 0, 0, exp_d[0]);
`endif

        step(0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tff_downcounter.md
# tff_downcounter

Synchronous, loadable down counter built from a T flip-flop chain. It is the counterpart of the asynchronous TFF up counter: it counts down from a loaded value to zero, then flags terminal count. It serves as a programmable interval/delay timer next to the up counter in the sequential-logic set, and all flops share one clock.

## Interface

Parameters:

- `WIDTH`, default 3: counter width in bits; the maximum load value is 2^WIDTH-1.

Ports:

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `load` input 1: load request; takes `load_val` on the next edge.
- `load_val` input WIDTH: start value for the countdown.
- `en` input 1: count enable; when low, the count holds.
- `q` output WIDTH: registered count value.
- `busy` output 1: registered; high while the block is in COUNT.
- `done` output 1: registered single-cycle terminal-count pulse.
- `zero` output 1: combinational; equals (q == 0).

## Operation

- **Reset.** One clock, synchronous, active-high reset. At the reset edge: q=0, busy=0, done=0, state=IDLE, internal reload register=0. Reset overrides load and en.
- **States.** The block has two states, IDLE and COUNT. `busy` = (state == COUNT).
- **Priority at each edge:** reset, then load, then en.
- **IDLE.**
  - q holds. done=0.
  - On load with load_val != 0: q <= load_val, reload register <= load_val, go to COUNT.
  - On load with load_val == 0: q <= 0, stay in IDLE, no done pulse.
  - en is ignored.
- **COUNT, en=1, q > 1:**
  - Decrement via T-FF chain. Bit 0 always toggles. Bit i toggles when bits [i-1:0] are all 0.
  - No binary subtractor is used for the next-state logic.
- **COUNT, en=1, q == 1 (terminal):**
  - done <= 1 for exactly one cycle.
  - Next state and q depend on the configuration (see Configuration).
- **COUNT, en=0:** q holds, done=0, state holds.
- **COUNT, load=1:**
  - Restart: q <= load_val, reload register <= load_val, done=0. The en on that edge is ignored.
  - load_val == 0: q <= 0, go to IDLE, no done.
- **Load on the terminal edge:** load wins. No done pulse is generated.
- **Wrap-around:** the counter never decrements below 0, and q never wraps to all-ones.

## Timing

- q, busy and done change only on rising edges. zero follows q combinationally.
- Load latency: 1 cycle. q = load_val in the cycle after the load edge.
- A load of N (N >= 1) followed by en held high: q reaches its terminal value on the Nth enabled edge after the load edge. done is high in the same cycle q first shows that value.
- Each low cycle of en stretches the countdown by exactly one cycle.
- done is never high in two consecutive cycles, except in auto-reload with reload value 1. In that case done is high on every enabled edge.
- Reset mid-count: at the next edge q=0, IDLE, done=0. A pending done is suppressed.

## Configuration

Macro `TFF_DOWNCOUNTER_AUTO_RELOAD_EN`.

- **Undefined (one-shot):** at the terminal edge q <= 0, state goes to IDLE, busy drops in the same cycle done rises. The block then waits for a new load.
- **Defined (periodic):**
  - At the terminal edge q <= reload register and the state stays in COUNT. busy stays high.
  - done pulses once every reload-value enabled cycles.
  - zero is never high while in COUNT.
  - Only load_val == 0 or reset returns the block to IDLE.

## Test plan

1. **Reset.** Assert reset for 2 cycles with load=1, load_val=5 and en=1 driven. Required: q=0, busy=0, done=0, zero=1 throughout; the load is ignored.
2. **One-shot count.** Load 5, then en=1 continuously. Required: q sequence 5,4,3,2,1,0. done=1 only in the cycle q=0 first appears, and busy falls in that same cycle. q stays 0 afterwards.
3. **Enable gating and maximum load.** Load 7, with en toggling 1,0,1,0. Required: q holds during each en=0 cycle. done appears 7 enabled edges after the load, i.e. 14 cycles after the load with this toggle pattern.
4. **Reload mid-count.** Load 6 and count to 3, then load 2. Required: q=2 next, then 1, then 0 with done. There is no done at the original schedule.
5. **Load zero and reset mid-count.**
   - Load 0: q=0, IDLE, no done.
   - Load 4, count to 2, then assert reset: next q=0, IDLE, and done never pulses.
6. **Periodic mode (macro defined).** Load 3 with en=1. Required: q sequence 3,2,1,3,2,1,3; done high in each cycle q returns to 3; busy stays 1. A subsequent load of 0 gives q=0 and busy=0.
